// File: rtl/counter_pkg.sv
// counter_pkg: command, state and mode encodings shared by the counter controller
package counter_pkg;
  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_START = 2'd2;
  localparam logic [1:0] OP_STOP  = 2'd3;
  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;
  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;
endpackage

// File: rtl/cnt_core.sv
// cnt_core: WIDTH-bit up-counter with clear/enable/hold and a >= limit compare
module cnt_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             ge
);
  assign ge = count >= limit;
  always_ff @(posedge clk or negedge rst)
    if (!rst) count <= '0;
    else if (clr) count <= '0;
    else if (en) count <= count + 1'b1;
endmodule

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: command-driven one-shot/periodic sequencer around cnt_core
// Optional count prescaler enabled by defining CNT_PRESCALE_EN.
module counter_seq_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int PRESCALE_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output logic             tc_pulse,
  output logic             busy,
  output logic             done
);
  state_t state, nxt;
  logic [WIDTH-1:0] limit;
  logic mode_r, acc, ld, st, sp, tick, ge, term, clr, en;
  if (PRESCALE_DIV < 2) begin : g_bad_div
    $error("PRESCALE_DIV must be >= 2");
  end
`ifdef CNT_PRESCALE_EN
  localparam int PW = $clog2(PRESCALE_DIV);
  logic [PW-1:0] psc;
  assign tick = state == RUN && psc == PW'(PRESCALE_DIV - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) psc <= '0;
    else psc <= (state != RUN || tick) ? '0 : psc + 1'b1;
`else
  assign tick = state == RUN;
`endif
  assign acc  = cmd_valid && cmd_ready;
  assign ld   = acc && cmd_op == OP_LOAD;
  assign st   = acc && cmd_op == OP_START;
  assign sp   = acc && cmd_op == OP_STOP;
  assign term = tick && ge;
  assign clr  = (ld && state != RUN) || (st && state == DONE) || (term && mode_r == MODE_PERIODIC);
  assign en   = tick && !term;
  // one-shot terminal wins over a simultaneous STOP
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = st ? RUN : IDLE;
      RUN:     nxt = (term && mode_r == MODE_ONESHOT) ? DONE : sp ? HOLD : RUN;
      HOLD:    nxt = st ? RUN : ld ? IDLE : HOLD;
      DONE:    nxt = st ? RUN : (ld || sp) ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      limit     <= '0;
      mode_r    <= MODE_ONESHOT;
      tc_pulse  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state     <= nxt;
      if (ld) limit <= cmd_data;
      if (st && state != RUN) mode_r <= mode;
      tc_pulse  <= term;
      busy      <= nxt == RUN;
      done      <= nxt == DONE;
      cmd_ready <= !(acc && cmd_op != OP_NOP);
    end
  cnt_core #(.WIDTH(WIDTH)) u_core (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .limit(limit), .count(count), .ge(ge)
  );
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl: directed self-checking bench for counter_seq_ctrl
module tb_counter_seq_ctrl;
  logic clk = 0, rst = 0, cmd_valid = 0, mode = 0;
  logic [1:0] cmd_op = 0;
  logic [3:0] cmd_data = 0;
  logic cmd_ready, tc_pulse, busy, done;
  logic [3:0] count;
  logic [7:0] obs, exp_v;
  int checks = 0, errors = 0;
  assign obs = {count, tc_pulse, done, busy, cmd_ready};
  counter_seq_ctrl #(.WIDTH(4), .PRESCALE_DIV(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .mode(mode), .count(count), .tc_pulse(tc_pulse), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic send(input logic [1:0] op, input logic [3:0] d, input logic m);
    cmd_valid = 1; cmd_op = op; cmd_data = d; mode = m;
    step();
    cmd_valid = 0; cmd_op = 0;
  endtask
  task automatic test_reset();
    step(); step();
    exp_v = {4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL reset {count,tc,done,busy,ready} got %h want %h", obs, exp_v); end
    @(negedge clk) rst = 1;
  endtask
  task automatic test_oneshot();
    send(2'd1, 4'd5, 0);
    exp_v = {4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL oneshot_load got %h want %h", obs, exp_v); end
    step();
    send(2'd2, 4'd0, 0);
    exp_v = {4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL oneshot_start got %h want %h", obs, exp_v); end
    for (int i = 1; i <= 5; i++) begin
      step();
      exp_v = {4'(i), 1'b0, 1'b0, 1'b1, 1'b1};
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL oneshot_count%0d got %h want %h", i, obs, exp_v); end
    end
    step();
    exp_v = {4'd5, 1'b1, 1'b1, 1'b0, 1'b1};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL oneshot_terminal got %h want %h", obs, exp_v); end
    step();
    exp_v = {4'd5, 1'b0, 1'b1, 1'b0, 1'b1};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL oneshot_done_hold got %h want %h", obs, exp_v); end
  endtask
  task automatic test_periodic();
    send(2'd1, 4'd3, 1);
    exp_v = {4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL periodic_load_from_done got %h want %h", obs, exp_v); end
    step();
    send(2'd2, 4'd0, 1);
    for (int i = 0; i < 8; i++) begin
      step();
      exp_v = {4'((i + 1) % 4), 1'((i + 1) % 4 == 0), 1'b0, 1'b1, 1'b1};
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL periodic_step%0d got %h want %h", i, obs, exp_v); end
    end
  endtask
  task automatic test_stop_resume();
    step();
    send(2'd3, 4'd0, 0);
    exp_v = {4'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL stop_hold got %h want %h", obs, exp_v); end
    step(); step(); step();
    exp_v = {4'd2, 1'b0, 1'b0, 1'b0, 1'b1};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL hold_idle_cycles got %h want %h", obs, exp_v); end
    send(2'd2, 4'd0, 1);
    exp_v = {4'd2, 1'b0, 1'b0, 1'b1, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL resume_start got %h want %h", obs, exp_v); end
    step();
    exp_v = {4'd3, 1'b0, 1'b0, 1'b1, 1'b1};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL resume_count got %h want %h", obs, exp_v); end
    step();
    exp_v = {4'd0, 1'b1, 1'b0, 1'b1, 1'b1};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL resume_wrap got %h want %h", obs, exp_v); end
  endtask
  task automatic test_load_in_run();
    send(2'd3, 4'd0, 0);
    step();
    send(2'd1, 4'd9, 1);
    exp_v = {4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL hold_load_to_idle got %h want %h", obs, exp_v); end
    step();
    send(2'd2, 4'd0, 1);
    for (int i = 0; i < 6; i++) step();
    exp_v = {4'd6, 1'b0, 1'b0, 1'b1, 1'b1};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL run_to_6 got %h want %h", obs, exp_v); end
    send(2'd1, 4'd4, 1);
    exp_v = {4'd7, 1'b0, 1'b0, 1'b1, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL run_load_continues got %h want %h", obs, exp_v); end
    step();
    exp_v = {4'd0, 1'b1, 1'b0, 1'b1, 1'b1};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL run_load_terminal got %h want %h", obs, exp_v); end
  endtask
  task automatic test_stop_on_terminal();
    for (int i = 0; i < 4; i++) step();
    send(2'd3, 4'd0, 0);
    exp_v = {4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL periodic_stop_terminal got %h want %h", obs, exp_v); end
    step();
    send(2'd2, 4'd0, 0);
    for (int i = 0; i < 4; i++) step();
    send(2'd3, 4'd0, 0);
    exp_v = {4'd4, 1'b1, 1'b1, 1'b0, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL oneshot_stop_terminal got %h want %h", obs, exp_v); end
    step();
    send(2'd3, 4'd0, 0);
    exp_v = {4'd4, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL done_stop_idle got %h want %h", obs, exp_v); end
  endtask
  task automatic test_limit_zero();
    step();
    send(2'd1, 4'd0, 0);
    step();
    send(2'd2, 4'd0, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      exp_v = {4'd0, 1'b1, 1'b0, 1'b1, 1'b1};
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL limit_zero_tick%0d got %h want %h", i, obs, exp_v); end
    end
  endtask
  task automatic test_async_reset();
    send(2'd1, 4'd15, 1);
    for (int i = 0; i < 7; i++) step();
    exp_v = {4'd7, 1'b0, 1'b0, 1'b1, 1'b1};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL pre_reset_count got %h want %h", obs, exp_v); end
    #2 rst = 0;
    #1;
    exp_v = {4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL async_reset got %h want %h", obs, exp_v); end
    @(negedge clk) rst = 1;
  endtask
  task automatic test_prescale();
    send(2'd1, 4'd2, 0);
    step();
    send(2'd2, 4'd0, 0);
    for (int c = 1; c <= 12; c++) begin
      step();
      exp_v = {4'(c < 12 ? c / 4 : 2), 1'(c == 12), 1'(c == 12), 1'(c != 12), 1'b1};
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL prescale_cycle%0d got %h want %h", c, obs, exp_v); end
    end
  endtask
  initial begin
    test_reset();
`ifdef CNT_PRESCALE_EN
    test_prescale();
`else
    test_oneshot();
    test_periodic();
    test_stop_resume();
    test_load_in_run();
    test_stop_on_terminal();
    test_limit_zero();
    test_async_reset();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
